// File: rtl/fpu_issue_ctrl_if.sv
// Command and result handshake bundle for the fpu issue front-end.
// The slave side is the issue controller; the master side is the user
// that sends float ops and consumes results.
interface fpu_issue_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_rmode;
  logic [31:0] cmd_opa;
  logic [31:0] cmd_opb;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [7:0]  res_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_rmode, cmd_opa, cmd_opb, res_ready,
    input  cmd_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rmode, cmd_opa, cmd_opb, res_ready,
    output cmd_ready, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue front-end for a fixed-latency, non-stallable fpu core.
// Registers the fpu operands, follows each issued op through a tag shift
// register, and captures fpu out/flags into a small result FIFO. Issue is
// credit-gated on (ops in flight + results queued) so a result always has a
// FIFO slot when it emerges from the fpu.
module fpu_issue_ctrl #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  fpu_issue_ctrl_if.slave     bus,
  output logic [2:0]          fpu_op,
  output logic [1:0]          fpu_rmode,
  output logic [31:0]         fpu_opa,
  output logic [31:0]         fpu_opb,
  input  logic [31:0]         fpu_out,
  input  logic [7:0]          fpu_flags,
  output logic                busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(LATENCY + FIFO_DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [SW-1:0] CREDIT_C = SW'(FIFO_DEPTH);

  // Operand registers feeding the fpu
  logic [2:0]  fpu_op_q, fpu_op_d;
  logic [1:0]  fpu_rmode_q, fpu_rmode_d;
  logic [31:0] fpu_opa_q, fpu_opa_d;
  logic [31:0] fpu_opb_q, fpu_opb_d;

  // One bit per fpu pipeline stage: set where a live op currently sits
  logic [LATENCY-1:0] tag_q, tag_d;

  // Result FIFO: storage array plus a registered head copy
  logic [31:0]   data_mem_q  [FIFO_DEPTH];
  logic [7:0]    flags_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcount_q, fcount_d;
  logic [31:0]   head_data_q, head_data_d;
  logic [7:0]    head_flags_q, head_flags_d;
  logic [AW-1:0] next_rd;

  logic [IW-1:0] inflight;
  logic          cmd_ready;
  logic          issue;
  logic          push;
  logic          pop;

  // Count live ops in the fpu pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + IW'(tag_q[i]);
    end
  end

  // Credit check uses registered state only, so ready never depends on valid
  assign cmd_ready = (SW'(inflight) + SW'(fcount_q)) < CREDIT_C;
  assign issue     = bus.cmd_valid && cmd_ready;
  assign push      = tag_q[LATENCY-1];
  assign pop       = bus.res_ready && (fcount_q != '0);

  // Tag pipe: new tag enters on issue, every stage shifts each cycle
  assign tag_d[0] = issue;
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag_shift
      assign tag_d[gi] = tag_q[gi-1];
    end
  endgenerate

  // Load fpu operands on issue, otherwise hold them steady
  always_comb begin
    fpu_op_d    = fpu_op_q;
    fpu_rmode_d = fpu_rmode_q;
    fpu_opa_d   = fpu_opa_q;
    fpu_opb_d   = fpu_opb_q;
    if (issue) begin
      fpu_op_d    = bus.cmd_op;
      fpu_rmode_d = bus.cmd_rmode;
      fpu_opa_d   = bus.cmd_opa;
      fpu_opb_d   = bus.cmd_opb;
    end
  end

  // FIFO pointer/occupancy update and head register refill
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fcount_d     = fcount_q;
    head_data_d  = head_data_q;
    head_flags_d = head_flags_q;
    next_rd      = rd_ptr_q + AW'(1);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = next_rd;

    if (push && !pop)      fcount_d = fcount_q + ONE_C;
    else if (!push && pop) fcount_d = fcount_q - ONE_C;

    // Following entry is already stored when more than one is queued;
    // otherwise the incoming capture becomes the head directly. An empty
    // FIFO keeps the last popped value on the head.
    if (pop && (fcount_q > ONE_C)) begin
      head_data_d  = data_mem_q[next_rd];
      head_flags_d = flags_mem_q[next_rd];
    end else if (push && ((fcount_q == '0) || (pop && (fcount_q == ONE_C)))) begin
      head_data_d  = fpu_out;
      head_flags_d = fpu_flags;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_op_q     <= '0;
      fpu_rmode_q  <= '0;
      fpu_opa_q    <= '0;
      fpu_opb_q    <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcount_q     <= '0;
      head_data_q  <= '0;
      head_flags_q <= '0;
    end else begin
      fpu_op_q     <= fpu_op_d;
      fpu_rmode_q  <= fpu_rmode_d;
      fpu_opa_q    <= fpu_opa_d;
      fpu_opb_q    <= fpu_opb_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcount_q     <= fcount_d;
      head_data_q  <= head_data_d;
      head_flags_q <= head_flags_d;
    end
  end

  // Result storage write, no reset needed on the array
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q]  <= fpu_out;
      flags_mem_q[wr_ptr_q] <= fpu_flags;
    end
  end

  // A capture into a full FIFO without a pop would lose a result
  assert property (@(posedge clk) disable iff (rst)
    !(push && (fcount_q == DEPTH_C) && !pop));

  assign fpu_op        = fpu_op_q;
  assign fpu_rmode     = fpu_rmode_q;
  assign fpu_opa       = fpu_opa_q;
  assign fpu_opb       = fpu_opb_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = (fcount_q != '0);
  assign bus.res_data  = head_data_q;
  assign bus.res_flags = head_flags_q;
  assign busy          = (inflight != '0) || (fcount_q != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a table-driven fpu stand-in.
module tb_fpu_issue_ctrl;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if bus ();

  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic [31:0] fpu_out;
  logic [7:0]  fpu_flags;
  logic        busy;

  fpu_issue_ctrl #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fpu_op    (fpu_op),
    .fpu_rmode (fpu_rmode),
    .fpu_opa   (fpu_opa),
    .fpu_opb   (fpu_opb),
    .fpu_out   (fpu_out),
    .fpu_flags (fpu_flags),
    .busy      (busy)
  );

  // fpu stand-in: known results for the vectors used here.
  // Unsupported op 7 yields opa^opb with the ine flag.
  function automatic logic [39:0] fpu_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [39:0] r;
    r = {32'hDEADBEEF, 8'h00};
    case (op)
      3'd0: if (a == 32'h3F800000) begin
        case (b)
          32'h3F800000: r = {32'h40000000, 8'h00};
          32'h40000000: r = {32'h40400000, 8'h00};
          32'h40400000: r = {32'h40800000, 8'h00};
          32'h40800000: r = {32'h40A00000, 8'h00};
          32'h40A00000: r = {32'h40C00000, 8'h00};
          32'h40C00000: r = {32'h40E00000, 8'h00};
          32'h40E00000: r = {32'h41000000, 8'h00};
          32'h41000000: r = {32'h41100000, 8'h00};
          default: ;
        endcase
      end
      3'd2: if (a == 32'h40000000 && b == 32'h40400000) r = {32'h40C00000, 8'h00};
      3'd3: if (a == 32'h3F800000 && b == 32'h00000000) r = {32'h7F800000, 8'h81};
      3'd7: r = {a ^ b, 8'h10};
      default: ;
    endcase
    return r;
  endfunction

  // fpu inputs change at edge E and the result must be settled before edge
  // E+LATENCY, so the stand-in carries LATENCY-1 register stages.
  logic [39:0] fpu_pipe [LATENCY-1];
  always_ff @(posedge clk) begin
    fpu_pipe[0] <= fpu_model(fpu_op, fpu_opa, fpu_opb);
    for (int k = 1; k < LATENCY - 1; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign {fpu_out, fpu_flags} = fpu_pipe[LATENCY-2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] add_b   [8];
  logic [31:0] add_exp [8];
  int          pop_cyc [8];
  logic        busy_hist [64];

  int          accepted, pops, idx, cyc, last_issue, vcount, pops_at_5;
  logic        acc, pp;
  logic [31:0] d;

  initial begin
    add_b[0] = 32'h3F800000; add_exp[0] = 32'h40000000;
    add_b[1] = 32'h40000000; add_exp[1] = 32'h40400000;
    add_b[2] = 32'h40400000; add_exp[2] = 32'h40800000;
    add_b[3] = 32'h40800000; add_exp[3] = 32'h40A00000;
    add_b[4] = 32'h40A00000; add_exp[4] = 32'h40C00000;
    add_b[5] = 32'h40C00000; add_exp[5] = 32'h40E00000;
    add_b[6] = 32'h40E00000; add_exp[6] = 32'h41000000;
    add_b[7] = 32'h41000000; add_exp[7] = 32'h41100000;

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_rmode = 2'd0;
    bus.cmd_opa   = 32'h0;
    bus.cmd_opb   = 32'h0;
    bus.res_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_data",  bus.res_data,       32'h0);
    chk("rst_res_flags", 32'(bus.res_flags), 32'h0);
    chk("rst_fpu_opa",   fpu_opa,            32'h0);
    rst = 1'b0;
    tick();

    // 1) 1.0 + 2.0
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_rmode = 2'd0;
    bus.cmd_opa = 32'h3F800000; bus.cmd_opb = 32'h40000000;
    tick();
    bus.cmd_valid = 1'b0;
    chk("t1_fpu_opa", fpu_opa, 32'h3F800000);
    chk("t1_fpu_opb", fpu_opb, 32'h40000000);
    chk("t1_fpu_op",  32'(fpu_op), 32'd0);
    chk("t1_busy",    32'(busy), 32'd1);
    tick(); tick(); tick();
    chk("t1_not_early", 32'(bus.res_valid), 32'd0);
    chk("t1_opa_hold",  fpu_opa, 32'h3F800000);
    tick();
    $display("t1 result data=0x%08h flags=0x%02h", bus.res_data, bus.res_flags);
    chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_res_data",  bus.res_data, 32'h40400000);
    chk("t1_res_flags", 32'(bus.res_flags), 32'h0);
    tick();
    chk("t1_hold_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_hold_data",  bus.res_data, 32'h40400000);
    bus.res_ready = 1'b1;
    tick();
    chk("t1_popped_valid", 32'(bus.res_valid), 32'd0);
    tick();
    bus.res_ready = 1'b0;
    chk("t1_empty_pop_valid", 32'(bus.res_valid), 32'd0);
    chk("t1_last_data_kept",  bus.res_data, 32'h40400000);
    chk("t1_idle_busy",       32'(busy), 32'd0);

    // 2) 1.0 / 0.0
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_rmode = 2'd1;
    bus.cmd_opa = 32'h3F800000; bus.cmd_opb = 32'h00000000;
    tick();
    bus.cmd_valid = 1'b0;
    chk("t2_fpu_op",    32'(fpu_op), 32'd3);
    chk("t2_fpu_rmode", 32'(fpu_rmode), 32'd1);
    tick(); tick(); tick(); tick();
    $display("t2 result data=0x%08h flags=0x%02h", bus.res_data, bus.res_flags);
    chk("t2_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t2_res_data",  bus.res_data, 32'h7F800000);
    chk("t2_res_flags", 32'(bus.res_flags), 32'h81);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Unsupported op code passes through
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_rmode = 2'd2;
    bus.cmd_opa = 32'h12345678; bus.cmd_opb = 32'h0F0F0F0F;
    tick();
    bus.cmd_valid = 1'b0;
    chk("t2u_fpu_op", 32'(fpu_op), 32'd7);
    tick(); tick(); tick(); tick();
    $display("t2u result data=0x%08h flags=0x%02h", bus.res_data, bus.res_flags);
    chk("t2u_res_data",  bus.res_data, 32'h1D3B5977);
    chk("t2u_res_flags", 32'(bus.res_flags), 32'h10);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // 3) Credit limit with consumer stalled: 6 muls 2.0*3.0
    bus.cmd_op = 3'd2; bus.cmd_rmode = 2'd0;
    bus.cmd_opa = 32'h40000000; bus.cmd_opb = 32'h40400000;
    bus.cmd_valid = 1'b1;
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.cmd_valid && bus.cmd_ready) accepted++;
      tick();
    end
    chk("t3_ready_low_after_4th", 32'(bus.cmd_ready), 32'd0);
    for (int c = 0; c < 8; c++) begin
      if (bus.cmd_valid && bus.cmd_ready) accepted++;
      tick();
    end
    chk("t3_accepted_stalled", 32'(accepted), 32'd4);
    chk("t3_res_valid", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    pops = 0; pops_at_5 = -1;
    for (int c = 0; c < 30 && (pops < 6 || accepted < 6); c++) begin
      acc = bus.cmd_valid && bus.cmd_ready;
      pp  = bus.res_valid && bus.res_ready;
      d   = bus.res_data;
      tick();
      if (acc) begin
        accepted++;
        if (accepted == 5) pops_at_5 = pops;
        if (accepted == 6) bus.cmd_valid = 1'b0;
      end
      if (pp) begin
        pops++;
        $display("t3 pop %0d data=0x%08h", pops, d);
        chk("t3_result", d, 32'h40C00000);
      end
    end
    bus.cmd_valid = 1'b0;
    chk("t3_accepted_total", 32'(accepted), 32'd6);
    chk("t3_pops_total",     32'(pops), 32'd6);
    chk("t3_credit_next_cycle", 32'(pops_at_5), 32'd1);
    chk("t3_busy_done",      32'(busy), 32'd0);

    // 4) Issue stream of distinct adds with consumer always ready
    bus.res_ready = 1'b1;
    bus.cmd_op = 3'd0; bus.cmd_opa = 32'h3F800000;
    idx = 0; bus.cmd_opb = add_b[0]; bus.cmd_valid = 1'b1;
    pops = 0; cyc = 0; last_issue = 0;
    for (int c = 0; c < 40; c++) begin
      acc = bus.cmd_valid && bus.cmd_ready;
      pp  = bus.res_valid && bus.res_ready;
      d   = bus.res_data;
      tick();
      cyc++;
      busy_hist[cyc] = busy;
      if (acc) begin
        last_issue = cyc;
        idx++;
        if (idx < 8) bus.cmd_opb = add_b[idx];
        else bus.cmd_valid = 1'b0;
      end
      if (pp) begin
        $display("t4 pop %0d data=0x%08h cycle=%0d", pops, d, cyc);
        if (pops < 8) begin
          chk("t4_result", d, add_exp[pops]);
          pop_cyc[pops] = cyc;
        end
        pops++;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("t4_issued", 32'(idx), 32'd8);
    chk("t4_pops",   32'(pops), 32'd8);
    for (int i = 0; i < 3; i++) begin
      chk("t4_back_to_back", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd1);
    end
    if (last_issue > 34) last_issue = 34;
    chk("t4_busy_at_L4", 32'(busy_hist[last_issue + LATENCY]), 32'd1);
    chk("t4_busy_at_L5", 32'(busy_hist[last_issue + LATENCY + 1]), 32'd0);

    // 5) Reset mid-operation
    bus.res_ready = 1'b0;
    bus.cmd_op = 3'd0; bus.cmd_opa = 32'h3F800000; bus.cmd_opb = 32'h3F800000;
    bus.cmd_valid = 1'b1;
    tick(); tick(); tick();
    bus.cmd_valid = 1'b0;
    tick(); tick();
    chk("t5_valid_before_rst", 32'(bus.res_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("t5_rst_busy",      32'(busy), 32'd0);
    chk("t5_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t5_rst_fpu_opa",   fpu_opa, 32'h0);
    chk("t5_rst_res_data",  bus.res_data, 32'h0);
    tick(); tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.res_valid) vcount++;
    end
    chk("t5_no_stale_results", 32'(vcount), 32'd0);
    chk("t5_busy_after",       32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
